// File: rtl/wb_arbiter_2m1s.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter.
// m0 is the instruction port, m1 the data port. Round-robin grant, held for a
// whole Wishbone cycle, with an outstanding-request counter so that responses
// only reach the master that owns the bus.
module wb_arbiter_2m1s #(
  parameter int ADR_WIDTH       = 32,
  parameter int DAT_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic                   m0_wb_cyc_i,
  input  logic                   m0_wb_stb_i,
  input  logic                   m0_wb_we_i,
  input  logic [ADR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                   m0_wb_stall_o,
  output logic                   m0_wb_ack_o,
  output logic                   m0_wb_err_o,
  output logic [DAT_WIDTH-1:0]   m0_wb_dat_o,

  input  logic                   m1_wb_cyc_i,
  input  logic                   m1_wb_stb_i,
  input  logic                   m1_wb_we_i,
  input  logic [ADR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                   m1_wb_stall_o,
  output logic                   m1_wb_ack_o,
  output logic                   m1_wb_err_o,
  output logic [DAT_WIDTH-1:0]   m1_wb_dat_o,

  output logic                   s_wb_cyc_o,
  output logic                   s_wb_stb_o,
  output logic                   s_wb_we_o,
  output logic [ADR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DAT_WIDTH-1:0]   s_wb_dat_o,
  output logic [DAT_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                   s_wb_stall_i,
  input  logic                   s_wb_ack_i,
  input  logic                   s_wb_err_i,
  input  logic [DAT_WIDTH-1:0]   s_wb_dat_i,

  output logic [1:0]             grant_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;     // 0 = m0 owned last, 1 = m1 owned last
  logic [CNT_W-1:0] count_q, count_d;
  logic             release_c;

  logic own0, own1;
  logic full, pending;
  logic accept, resp, resp_used;

  assign own0    = (state_q == GNT0);
  assign own1    = (state_q == GNT1);
  assign full    = (count_q == CNT_MAX);
  assign pending = (count_q != '0);

  // A response only counts (and is only forwarded) while the owner has
  // requests in flight; stragglers from an aborted cycle fall on count = 0.
  // This assumes the slave never acks in the same cycle it accepts a strobe.
  assign accept    = s_wb_stb_o & ~s_wb_stall_i;
  assign resp      = s_wb_ack_i | s_wb_err_i;
  assign resp_used = resp & (own0 | own1) & pending;

  assign grant_o = {own1, own0};

  // Arbitration state, last-owner bit and outstanding counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Next grant: round-robin from IDLE, release only when the owner drops cyc
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    count_d   = count_q;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_q)) begin
          state_d = GNT0;
        end else if (m1_wb_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_wb_cyc_i) begin
          release_c = 1'b1;
          last_d    = 1'b0;
          count_d   = '0;
          state_d   = m1_wb_cyc_i ? GNT1 : IDLE;
        end else begin
          count_d = count_q + CNT_W'(accept) - CNT_W'(resp_used);
        end
      end
      GNT1: begin
        if (!m1_wb_cyc_i) begin
          release_c = 1'b1;
          last_d    = 1'b1;
          count_d   = '0;
          state_d   = m0_wb_cyc_i ? GNT0 : IDLE;
        end else begin
          count_d = count_q + CNT_W'(accept) - CNT_W'(resp_used);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave request mux: owner passes through, strobe held off while full
  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    if (own0) begin
      s_wb_cyc_o = m0_wb_cyc_i;
      s_wb_stb_o = m0_wb_stb_i & ~full;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_dat_o = m0_wb_dat_i;
      s_wb_sel_o = m0_wb_sel_i;
    end else if (own1) begin
      s_wb_cyc_o = m1_wb_cyc_i;
      s_wb_stb_o = m1_wb_stb_i & ~full;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_dat_o = m1_wb_dat_i;
      s_wb_sel_o = m1_wb_sel_i;
    end
  end

  // Master responses: owner sees the slave, a waiting master just sees stall
  always_comb begin
    m0_wb_stall_o = own0 ? (s_wb_stall_i | full) : m0_wb_cyc_i;
    m0_wb_ack_o   = own0 & pending & s_wb_ack_i;
    m0_wb_err_o   = own0 & pending & s_wb_err_i;
    m0_wb_dat_o   = own0 ? s_wb_dat_i : '0;
    m1_wb_stall_o = own1 ? (s_wb_stall_i | full) : m1_wb_cyc_i;
    m1_wb_ack_o   = own1 & pending & s_wb_ack_i;
    m1_wb_err_o   = own1 & pending & s_wb_err_i;
    m1_wb_dat_o   = own1 ? s_wb_dat_i : '0;
  end

`ifndef SYNTHESIS
  // Requests abandoned by an aborted cycle may still be answered later;
  // track them so only truly unsolicited responses are flagged.
  logic [7:0] orphan_q;

  // Orphaned-request bookkeeping and unsolicited-response check
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      orphan_q <= '0;
    end else begin
      if (resp && !resp_used) begin
        assert (orphan_q != '0)
          else $error("wb_arbiter_2m1s: slave response with no outstanding request");
      end
      if (release_c) begin
        orphan_q <= orphan_q + 8'(count_q) - 8'(resp_used);
      end else if (resp && !resp_used && orphan_q != '0) begin
        orphan_q <= orphan_q - 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Directed bench for wb_arbiter_2m1s: a MAX_OUTSTANDING=4 instance for the
// arbitration scenarios and a MAX_OUTSTANDING=2 instance for the full limit.
module tb_wb_arbiter_2m1s;

  logic        clk;
  logic        reset_n;

  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_wdat;
  logic [3:0]  m0_sel;
  logic        m0_stall, m0_ack, m0_err;
  logic [31:0] m0_rdat;

  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_wdat;
  logic [3:0]  m1_sel;
  logic        m1_stall, m1_ack, m1_err;
  logic [31:0] m1_rdat;

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        s_stall, s_ack, s_err;
  logic [31:0] s_rdat;
  logic [1:0]  grant;

  // second instance (MAX_OUTSTANDING = 2)
  logic        c_m0_cyc, c_m0_stb, c_ack;
  logic        c_m0_stall, c_m0_ack, c_m0_err;
  logic [31:0] c_m0_rdat;
  logic        c_m1_stall, c_m1_ack, c_m1_err;
  logic [31:0] c_m1_rdat;
  logic        c_s_cyc, c_s_stb, c_s_we;
  logic [31:0] c_s_adr, c_s_wdat;
  logic [3:0]  c_s_sel;
  logic [1:0]  c_grant;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter_2m1s #(.ADR_WIDTH(32), .DAT_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .reset_i(reset_n),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat), .m0_wb_sel_i(m0_sel),
    .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m0_wb_dat_o(m0_rdat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat), .m1_wb_sel_i(m1_sel),
    .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .m1_wb_dat_o(m1_rdat),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .s_wb_dat_i(s_rdat),
    .grant_o(grant)
  );

  wb_arbiter_2m1s #(.ADR_WIDTH(32), .DAT_WIDTH(32), .MAX_OUTSTANDING(2)) dut2 (
    .clk_i(clk), .reset_i(reset_n),
    .m0_wb_cyc_i(c_m0_cyc), .m0_wb_stb_i(c_m0_stb), .m0_wb_we_i(1'b0),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(32'h0), .m0_wb_sel_i(4'hF),
    .m0_wb_stall_o(c_m0_stall), .m0_wb_ack_o(c_m0_ack), .m0_wb_err_o(c_m0_err),
    .m0_wb_dat_o(c_m0_rdat),
    .m1_wb_cyc_i(1'b0), .m1_wb_stb_i(1'b0), .m1_wb_we_i(1'b0),
    .m1_wb_adr_i(32'h0), .m1_wb_dat_i(32'h0), .m1_wb_sel_i(4'h0),
    .m1_wb_stall_o(c_m1_stall), .m1_wb_ack_o(c_m1_ack), .m1_wb_err_o(c_m1_err),
    .m1_wb_dat_o(c_m1_rdat),
    .s_wb_cyc_o(c_s_cyc), .s_wb_stb_o(c_s_stb), .s_wb_we_o(c_s_we),
    .s_wb_adr_o(c_s_adr), .s_wb_dat_o(c_s_wdat), .s_wb_sel_o(c_s_sel),
    .s_wb_stall_i(1'b0), .s_wb_ack_i(c_ack), .s_wb_err_i(1'b0),
    .s_wb_dat_i(s_rdat),
    .grant_o(c_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack = 0; s_err = 0; s_stall = 0;
    c_m0_cyc = 0; c_m0_stb = 0; c_ack = 0;
    nc(); nc();
  endtask

  task automatic test_reset();
    reset_n = 0;
    m0_cyc = 1; m1_cyc = 1; m0_stb = 0; m1_stb = 0;
    nc(); nc(); #2;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", grant); end
    n_chk++; if ({m0_stall, m1_stall} !== 2'b11) begin n_fail++; $display("FAIL rst_stall: got %b want 11", {m0_stall, m1_stall}); end
    n_chk++; if ({s_cyc, s_stb, s_adr} !== 34'h0) begin n_fail++; $display("FAIL rst_slave: got cyc=%b stb=%b adr=%h want 0", s_cyc, s_stb, s_adr); end
    nc(); reset_n = 1; #2;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_rel_grant: got %b want 00", grant); end
    nc(); #2;
    n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b want 01", grant); end
    n_chk++; if ({m1_stall, m1_ack, m0_stall, s_cyc} !== 4'b1001) begin n_fail++; $display("FAIL rst_first_resp: got m1stall/m1ack/m0stall/scyc=%b want 1001", {m1_stall, m1_ack, m0_stall, s_cyc}); end
    go_idle();
  endtask

  task automatic test_pipelined_reads();
    logic [31:0] rd [3];
    rd[0] = 32'hA000_0000; rd[1] = 32'hA000_0001; rd[2] = 32'hA000_0002;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; #2;
    n_chk++; if ({m0_stall, s_cyc} !== 2'b10) begin n_fail++; $display("FAIL rd_wait: got stall/scyc=%b want 10", {m0_stall, s_cyc}); end
    nc(); #2;
    n_chk++; if ({s_stb, s_adr, m0_stall} !== {1'b1, 32'h100, 1'b0}) begin n_fail++; $display("FAIL rd_req0: got stb=%b adr=%h stall=%b want 1 100 0", s_stb, s_adr, m0_stall); end
    nc(); m0_adr = 32'h104; #2;
    n_chk++; if (s_adr !== 32'h104) begin n_fail++; $display("FAIL rd_req1: got adr %h want 104", s_adr); end
    nc(); m0_adr = 32'h108;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin nc(); m0_stb = 0; end
      s_ack = 1; s_rdat = rd[i]; #2;
      n_chk++; if ({m0_ack, m0_rdat} !== {1'b1, rd[i]}) begin n_fail++; $display("FAIL rd_ack%0d: got ack=%b dat=%h want 1 %h", i, m0_ack, m0_rdat, rd[i]); end
      n_chk++; if ({m1_ack, m1_rdat} !== 33'h0) begin n_fail++; $display("FAIL rd_m1_quiet%0d: got ack=%b dat=%h want 0", i, m1_ack, m1_rdat); end
    end
    nc(); s_ack = 0; #2;
    n_chk++; if ({m0_ack, m0_stall, grant} !== 4'b0001) begin n_fail++; $display("FAIL rd_done: got ack/stall/grant=%b want 0001", {m0_ack, m0_stall, grant}); end
    go_idle();
  endtask

  task automatic test_full_limit();
    c_m0_cyc = 1; c_m0_stb = 1; m0_adr = 32'h40;
    nc(); #2;
    n_chk++; if ({c_s_stb, c_m0_stall} !== 2'b10) begin n_fail++; $display("FAIL full_first: got stb/stall=%b want 10", {c_s_stb, c_m0_stall}); end
    nc(); nc(); #2;
    n_chk++; if ({c_s_stb, c_m0_stall} !== 2'b01) begin n_fail++; $display("FAIL full_third: got stb/stall=%b want 01", {c_s_stb, c_m0_stall}); end
    nc(); #2;
    n_chk++; if ({c_s_stb, c_m0_stall} !== 2'b01) begin n_fail++; $display("FAIL full_hold: got stb/stall=%b want 01", {c_s_stb, c_m0_stall}); end
    nc(); c_ack = 1; s_rdat = 32'h1111_2222; #2;
    n_chk++; if ({c_m0_ack, c_s_stb, c_m0_rdat} !== {2'b10, 32'h1111_2222}) begin n_fail++; $display("FAIL full_ack: got ack=%b stb=%b dat=%h want 1 0 11112222", c_m0_ack, c_s_stb, c_m0_rdat); end
    nc(); c_ack = 0; #2;
    n_chk++; if ({c_s_stb, c_m0_stall} !== 2'b10) begin n_fail++; $display("FAIL full_reopen: got stb/stall=%b want 10", {c_s_stb, c_m0_stall}); end
    nc(); c_m0_stb = 0; c_ack = 1;
    nc();
    nc(); c_ack = 0;
    go_idle();
  endtask

  task automatic test_round_robin();
    m0_cyc = 1; m0_stb = 0; m0_adr = 32'h200; m1_adr = 32'h300;
    nc(); m0_stb = 1; m1_cyc = 1; m1_stb = 1; #2;
    n_chk++; if ({grant, s_adr, m1_stall} !== {2'b01, 32'h200, 1'b1}) begin n_fail++; $display("FAIL rr_m0_own: got grant=%b adr=%h m1stall=%b want 01 200 1", grant, s_adr, m1_stall); end
    nc(); m0_stb = 0; s_ack = 1; s_rdat = 32'hD0; #2;
    n_chk++; if ({m0_ack, m1_ack} !== 2'b10) begin n_fail++; $display("FAIL rr_m0_ack: got m0/m1 ack=%b want 10", {m0_ack, m1_ack}); end
    nc(); m0_cyc = 0; s_ack = 0; #2;
    n_chk++; if ({s_cyc, grant, m1_stall} !== 4'b0011) begin n_fail++; $display("FAIL rr_gap: got scyc/grant/m1stall=%b want 0011", {s_cyc, grant, m1_stall}); end
    nc(); m0_cyc = 1; #2;
    n_chk++; if ({grant, s_cyc, s_adr, m1_stall, m0_stall} !== {3'b101, 32'h300, 2'b01}) begin n_fail++; $display("FAIL rr_m1_own: got grant=%b scyc=%b adr=%h m1stall=%b m0stall=%b want 10 1 300 0 1", grant, s_cyc, s_adr, m1_stall, m0_stall); end
    nc(); m1_stb = 0; s_ack = 1; s_rdat = 32'hD1; #2;
    n_chk++; if ({m1_ack, m1_rdat, m0_ack} !== {1'b1, 32'hD1, 1'b0}) begin n_fail++; $display("FAIL rr_m1_ack: got m1ack=%b dat=%h m0ack=%b want 1 d1 0", m1_ack, m1_rdat, m0_ack); end
    nc(); m1_cyc = 0; s_ack = 0; #2;
    n_chk++; if ({s_cyc, grant} !== 3'b010) begin n_fail++; $display("FAIL rr_gap2: got scyc/grant=%b want 010", {s_cyc, grant}); end
    nc(); #2;
    n_chk++; if ({grant, s_adr} !== {2'b01, 32'h200}) begin n_fail++; $display("FAIL rr_back_m0: got grant=%b adr=%h want 01 200", grant, s_adr); end
    go_idle();
  endtask

  task automatic test_late_ack();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h400; m1_wdat = 32'h55;
    nc(); #2;
    n_chk++; if ({grant, s_we, s_wdat} !== {3'b101, 32'h55}) begin n_fail++; $display("FAIL la_write: got grant=%b we=%b dat=%h want 10 1 55", grant, s_we, s_wdat); end
    nc(); m1_adr = 32'h404; m1_wdat = 32'h66;
    nc(); m1_cyc = 0; m1_stb = 0; m0_cyc = 1; #2;
    n_chk++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL la_gap: got scyc=%b want 0", s_cyc); end
    for (int i = 0; i < 2; i++) begin
      nc(); s_ack = 1; s_rdat = 32'hBAD; #2;
      n_chk++; if ({grant, m0_ack, m1_ack} !== 4'b0100) begin n_fail++; $display("FAIL la_mask%0d: got grant=%b m0ack=%b m1ack=%b want 01 0 0", i, grant, m0_ack, m1_ack); end
    end
    nc(); s_ack = 0; m0_stb = 1; m0_we = 0; m0_adr = 32'h500; #2;
    n_chk++; if ({s_stb, s_adr, m0_stall} !== {1'b1, 32'h500, 1'b0}) begin n_fail++; $display("FAIL la_next_req: got stb=%b adr=%h stall=%b want 1 500 0", s_stb, s_adr, m0_stall); end
    nc(); m0_stb = 0; s_ack = 1; s_err = 1; s_rdat = 32'h77; #2;
    n_chk++; if ({m0_ack, m0_err, m0_rdat} !== {2'b11, 32'h77}) begin n_fail++; $display("FAIL la_next_ack: got ack=%b err=%b dat=%h want 1 1 77", m0_ack, m0_err, m0_rdat); end
    go_idle();
  endtask

  task automatic test_reset_mid_transfer();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h600; m0_adr = 32'h700;
    nc(); nc(); nc(); nc(); #2;
    n_chk++; if ({grant, s_stb, m1_stall} !== 4'b1010) begin n_fail++; $display("FAIL mr_count3: got grant=%b stb=%b stall=%b want 10 1 0", grant, s_stb, m1_stall); end
    m0_cyc = 1; reset_n = 0; #1;
    n_chk++; if ({s_cyc, s_stb, s_adr, grant} !== 36'h0) begin n_fail++; $display("FAIL mr_async: got cyc=%b stb=%b adr=%h grant=%b want 0", s_cyc, s_stb, s_adr, grant); end
    n_chk++; if ({m0_stall, m1_stall} !== 2'b11) begin n_fail++; $display("FAIL mr_stall: got %b want 11", {m0_stall, m1_stall}); end
    nc(); reset_n = 1;
    nc(); #2;
    n_chk++; if ({grant, s_adr, m1_stall} !== {2'b01, 32'h700, 1'b1}) begin n_fail++; $display("FAIL mr_tie: got grant=%b adr=%h m1stall=%b want 01 700 1", grant, s_adr, m1_stall); end
    go_idle();
  endtask

  initial begin
    reset_n = 0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_wdat = 0; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_wdat = 0; m1_sel = 4'hF;
    s_stall = 0; s_ack = 0; s_err = 0; s_rdat = 0;
    c_m0_cyc = 0; c_m0_stb = 0; c_ack = 0;
    test_reset();
    test_pipelined_reads();
    test_full_limit();
    test_round_robin();
    test_late_ack();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m1s.md
Name: wb_arbiter_2m1s

Overview:
- Two-master, one-slave Wishbone B4 pipelined arbiter with round-robin grant and outstanding-transaction tracking.
- Masters are the core's instruction port (m0) and data port (m1).
- Lets both ports share one single-ported slave, such as a single-port memory_2rw_wb port or a shared peripheral bus segment.
- Each grant is held for a whole Wishbone cycle; responses are routed only to the owning master.

Parameters:
- ADR_WIDTH, 32, address width of masters and slave.
- DAT_WIDTH, 32, data width; SEL width is DAT_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests per grant; minimum 1.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous active-low reset.
- m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each  master 0 cycle, strobe and write enable.
- m0_wb_adr_i  in  ADR_WIDTH  master 0 address.
- m0_wb_dat_i  in  DAT_WIDTH  master 0 write data.
- m0_wb_sel_i  in  DAT_WIDTH/8  master 0 byte selects.
- m0_wb_stall_o, m0_wb_ack_o, m0_wb_err_o  out  1 each  master 0 responses.
- m0_wb_dat_o  out  DAT_WIDTH  master 0 read data.
- m1_wb_*: same set and widths as m0, for master 1.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  slave cycle, strobe and write enable.
- s_wb_adr_o  out  ADR_WIDTH  slave address.
- s_wb_dat_o  out  DAT_WIDTH  slave write data.
- s_wb_sel_o  out  DAT_WIDTH/8  slave byte selects.
- s_wb_stall_i, s_wb_ack_i, s_wb_err_i  in  1 each  slave responses.
- s_wb_dat_i  in  DAT_WIDTH  slave read data.
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.

Behaviour:
- State register with three states: IDLE, GNT0, GNT1. Also a last-owner bit and an outstanding counter of width clog2(MAX_OUTSTANDING+1).
- Reset (reset_i low, asynchronous):
  - state = IDLE, last = m1 so m0 wins the first tie, count = 0.
  - All outputs 0, except mX_wb_stall_o = 1 whenever mX_wb_cyc_i = 1.
- Transitions out of IDLE (registered, sampled on the clock edge):
  - Only m0 cyc high -> GNT0.
  - Only m1 cyc high -> GNT1.
  - Both high -> the master that is not `last`.
  - Neither high -> stay IDLE.
- Transitions out of GNTx:
  - Owner cyc low on the edge -> release: go to GNTy if the other master's cyc is high, else IDLE. Set last = x and count = 0.
  - Owner cyc high -> stay in GNTx. A grant is never pre-empted.
- Grant latency: the grant appears on the edge after a master raises cyc, so a requesting master sees at least one stall cycle.
- Slave gets at least one cyc-low cycle between owners: in the release cycle the owner's cyc is already low, so s_wb_cyc_o = 0.
- Slave drive:
  - In GNTx, s_wb_cyc_o = mx cyc, and s_wb_stb_o = mx stb AND NOT full. we, adr, dat and sel pass through from mx.
  - In IDLE, all slave outputs are 0.
  - full = (count == MAX_OUTSTANDING).
- Owner responses:
  - mx_wb_stall_o = s_wb_stall_i OR full.
  - ack, err and dat pass through from the slave.
- Non-owner responses:
  - stall = its cyc (stall is 0 when its cyc is low).
  - ack = 0, err = 0, dat = 0.
- Counter:
  - +1 on accept (s_wb_stb_o AND NOT s_wb_stall_i).
  - -1 on response (s_wb_ack_i OR s_wb_err_i).
  - Accept and response in the same cycle -> count unchanged.
  - Never wraps. A response arriving with count = 0 is ignored (count stays 0); assertion in simulation.
- Abort: the owner dropping cyc with count > 0 clears count. Late slave acks after release are masked by count = 0 and the grant change, and are never forwarded to the new owner.
- Ack and err both high: forward both. The counter decrements once.
- grant_o = {state==GNT1, state==GNT0}.

Test Plan:
- Reset with both cyc high, then release reset -> grant_o = 01 on the first edge; m1_wb_stall_o = 1 and m1_wb_ack_o = 0 throughout.
- m0 issues 3 pipelined reads at 0x0000_0100/104/108; slave acks 2 cycles after each -> m0 gets 3 acks with slave data in order; count returns to 0; m1 never sees ack.
- MAX_OUTSTANDING = 2, slave never stalls and withholds acks -> third m0 strobe is stalled and s_wb_stb_o = 0 until the first ack arrives.
- Both masters hold cyc continuously; m0 drops cyc after 1 transfer -> one cycle with s_wb_cyc_o = 0, then grant_o = 10. When m1 drops, m0 (re-requesting) is granted: round-robin alternation.
- m1 owns the bus with 2 outstanding writes and drops cyc; slave then acks late -> the ack is not seen by m0; count = 0; next m0 transfer completes normally.
- reset_i pulsed low mid-transfer (count = 3, GNT1) -> all slave outputs 0 immediately, grant_o = 00; after release, m0 wins the tie.
